ysyx_25050147_sram_resp: RTL and testbench
==========================================

YSYX_25050147_SRAM_RESP -- requirements
Module: ysyx_25050147_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, meaning byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid; legal range is 1..15.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1, meaning the responder can accept a request.
REQ-008 SHALL have port req_wen, input, 1, meaning 1 is a write and 0 is a read.
REQ-009 SHALL have port req_addr, input, 32, meaning the byte address; bits [1:0] are ignored.
REQ-010 SHALL have port req_wdata, input, 32, meaning the store data.
REQ-011 SHALL have port req_wmask, input, 8, meaning byte-lane enables; bits [3:0] select bytes 0..3 and bits [7:4] are ignored.
REQ-012 SHALL have port resp_valid, output, 1, meaning a response is presented.
REQ-013 SHALL have port resp_ready, input, 1, meaning the initiator accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32, meaning the read data; it is 0 for writes and for errors.
REQ-015 SHALL have port resp_err, output, 1, meaning the address was out of range.

Function
REQ-016 SHALL implement states IDLE, BUSY and RESP.
REQ-017 SHALL drive req_ready = (state==IDLE) && !rst; a request is accepted on a rising edge where req_valid && req_ready.
REQ-018 SHALL, on acceptance, register wen, addr, wdata and wmask, load the delay counter with the total delay minus 1, and enter BUSY.
REQ-019 SHALL, in BUSY, decrement the counter each cycle; when the counter is 0, the next edge commits the access and enters RESP.
REQ-020 SHALL assert resp_valid exactly LATENCY edges after the acceptance edge (fixed-delay build), held with stable rdata and err until the edge where resp_valid && resp_ready, then return to IDLE.
REQ-021 SHALL treat an address as in range iff BASE <= addr < BASE+4*DEPTH; the word index is (addr-BASE)[log2(DEPTH)+1:2].
REQ-022 SHALL, for an in-range write, update only the bytes whose wmask[i] is set, at the commit edge; wmask[3:0]=0 is a legal no-op write.
REQ-023 SHALL, for an in-range read, return the word's value as of the commit edge, which includes any write committed earlier.
REQ-024 SHALL, for an out-of-range access, set resp_err=1, set resp_rdata=0, and perform no memory update.
REQ-025 SHALL ignore req_valid in BUSY and RESP; the requester holds its signals until acceptance.
REQ-026 SHALL allow resp_ready to be asserted before resp_valid, and SHALL complete the handshake on the first edge where both are high.
REQ-027 SHALL sustain a minimum issue interval of LATENCY+2 cycles (accept, delay, response handshake, return to IDLE).

Reset
REQ-028 SHALL, while rst is high at an edge, force state IDLE, counter 0, resp_valid 0, resp_rdata 0 and resp_err 0; req_ready reads 0 during rst.
REQ-029 SHALL, on reset in BUSY, drop the transaction without a memory update; on reset in RESP, drop the response.
REQ-030 SHALL leave memory contents unaffected by reset.

Configuration
REQ-031 SHALL, when macro YSYX_25050147_RAND_DELAY_EN is defined, include an 8-bit LFSR (taps 8,6,5,4; seed 8'hA5 on reset; advances every cycle) and add lfsr[1:0] (0..3) extra cycles to the delay sampled at acceptance.
REQ-032 SHALL, when YSYX_25050147_RAND_DELAY_EN is undefined, have no LFSR and a delay of exactly LATENCY.

Verification
REQ-033 SHALL verify write then read: write 0x80000010 data 0xDEADBEEF wmask 8'h0F, then read 0x80000010 -> rdata 0xDEADBEEF, err 0, resp_valid 2 edges after each accept (LATENCY=2).
REQ-034 SHALL verify byte masking: after the above, write 0x11223344 wmask 8'h05, then read -> 0xDE22BE44.
REQ-035 SHALL verify range errors: read 0x7FFFFFFC and 0x80004000 (DEPTH=4096) -> err 1, rdata 0; a write to 0x80004000 leaves word 0 unchanged.
REQ-036 SHALL verify backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable and req_ready stays 0; then resp_ready=1 -> IDLE one edge later.
REQ-037 SHALL verify reset mid-operation: assert rst for one cycle in BUSY during a write of 0xCAFEF00D -> no response, req_ready 1 after reset, and a subsequent read returns the old value.
REQ-038 SHALL verify the macro build: with YSYX_25050147_RAND_DELAY_EN defined, 100 random accesses -> each latency is within LATENCY..LATENCY+3 and all data matches a reference model.

Source files
------------

// File: rtl/ysyx_25050147_sram_resp.sv
// Word-addressed SRAM responder with a valid/ready request channel and a fixed-delay response.
// Optional macro YSYX_25050147_RAND_DELAY_EN adds 0..3 LFSR-driven extra delay cycles per access.
module ysyx_25050147_sram_resp #(
   parameter int          DEPTH   = 4096,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int          LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [4:0]  r_cnt;
   logic        r_wen;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wmask;
   logic        r_resp_valid;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH];

   logic        w_accept;
   logic        w_commit;
   logic [31:0] w_offset;
   logic        w_in_range;
   logic [AW-1:0] w_idx;
   logic [1:0]  w_extra;
   logic [4:0]  w_delay_m1;
   logic        w_unused;

`ifdef YSYX_25050147_RAND_DELAY_EN
   logic [7:0] r_lfsr;

   // x^8 + x^6 + x^5 + x^4 + 1, free-running so the extra delay depends on accept time.
   always_ff @(posedge clk) begin
      if (rst) r_lfsr <= 8'hA5;
      else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end

   assign w_extra = r_lfsr[1:0];
`else
   assign w_extra = 2'b00;
`endif

   assign req_ready  = (r_state == IDLE) && !rst;
   assign w_accept   = req_valid && req_ready;
   assign w_delay_m1 = 5'(LATENCY - 1) + {3'b000, w_extra};

   // Subtracting first keeps the upper-bound test free of BASE+4*DEPTH overflow.
   assign w_offset   = r_addr - BASE;
   assign w_in_range = (r_addr >= BASE) && (w_offset[31:AW+2] == '0);
   assign w_idx      = w_offset[AW+1:2];
   assign w_commit   = (r_state == BUSY) && (r_cnt == 5'd0) && !rst;
   assign w_unused   = ^{req_wmask[7:4], w_offset[1:0]};

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = BUSY;
         BUSY:    if (r_cnt == 5'd0) w_state_nxt = RESP;
         RESP:    if (resp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: request fields are plain capture registers, only meaningful after an accept, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_wen   <= req_wen;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_wmask <= req_wmask[3:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= 5'd0;
         r_resp_valid <= 1'b0;
         r_rdata      <= 32'd0;
         r_err        <= 1'b0;
      end else begin
         if (w_accept)
            r_cnt <= w_delay_m1;
         else if ((r_state == BUSY) && (r_cnt != 5'd0))
            r_cnt <= r_cnt - 5'd1;

         if (w_commit) begin
            r_resp_valid <= 1'b1;
            r_err        <= !w_in_range;
            r_rdata      <= (!r_wen && w_in_range) ? r_mem[w_idx] : 32'd0;
         end else if ((r_state == RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
         end
      end
   end

   // NOTE: the memory array is deliberately not reset; contents survive rst and map to plain RAM.
   always_ff @(posedge clk) begin
      if (w_commit && r_wen && w_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wmask[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25050147_sram_resp.sv
// Directed bench for ysyx_25050147_sram_resp: vector table plus hand sequences for
// backpressure and reset corners; random-delay build adds a model-checked random run.
module tb_ysyx_25050147_sram_resp;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   ysyx_25050147_sram_resp #(
      .DEPTH  (4096),
      .BASE   (32'h8000_0000),
      .LATENCY(LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  wmask;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_latency(input int lat);
`ifdef YSYX_25050147_RAND_DELAY_EN
      check("latency_range", 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
`else
      check("latency", 32'(lat), 32'(LAT));
`endif
   endtask

   // Drives a request at a negedge and returns at the negedge right after the accept edge.
   task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] wmask, output logic ok);
      int guard;
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      ok = req_ready;
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   // Counts edges after the accept edge until resp_valid is seen.
   task automatic wait_resp(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!resp_valid && lat < 40);
   endtask

   task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [7:0] wmask, output logic [31:0] rdata, output logic err);
      logic ok;
      int   lat;
      resp_ready = 1'b1;
      issue(wen, addr, wdata, wmask, ok);
      rdata = 32'hxxxx_xxxx;
      err   = 1'bx;
      if (ok) begin
         wait_resp(lat);
         check_latency(lat);
         rdata = resp_rdata;
         err   = resp_err;
         @(posedge clk);
         @(negedge clk);
         check("idle_after_handshake", {30'd0, resp_valid, req_ready}, 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        ok;
      int          lat;

      vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 8'h00, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 8'h05, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 8'h00, 32'hDE22_BE44, 1'b0};
      vecs[4]  = '{1'b1, 32'h8000_0000, 32'h0BAD_CAFE, 8'h0F, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b0, 32'h8000_4000, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 8'h00, 32'h0BAD_CAFE, 1'b0};
      vecs[9]  = '{1'b1, 32'h8000_3FFC, 32'h1234_5678, 8'h0F, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b0, 32'h8000_3FFF, 32'h0000_0000, 8'h00, 32'h1234_5678, 1'b0};
      vecs[11] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 32'h8000_0012, 32'h0000_0000, 8'h00, 32'hDE22_BE44, 1'b0};
      vecs[13] = '{1'b1, 32'h8000_0000, 32'hAABB_CCDD, 8'h0A, 32'h0000_0000, 1'b0};
      vecs[14] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 8'h00, 32'hAAAD_CCFE, 1'b0};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_wmask  = 8'd0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].err});
      end

      // Backpressure: response must hold still while resp_ready is low.
      resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0010, 32'd0, 8'h00, ok);
      wait_resp(lat);
      check_latency(lat);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, resp_valid}, 32'd1);
         check("bp_rdata", resp_rdata, 32'hDE22_BE44);
         check("bp_err", {31'd0, resp_err}, 32'd0);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
      check("bp_release_ready", {31'd0, req_ready}, 32'd1);

      // Reset while BUSY drops the write.
      resp_ready = 1'b1;
      issue(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 8'h0F, ok);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("busy_rst_req_ready", {31'd0, req_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("busy_rst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      txn(1'b0, 32'h8000_0010, 32'd0, 8'h00, rd, er);
      check("busy_rst_old_value", rd, 32'hDE22_BE44);

      // Reset while RESP drops the response.
      resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0000, 32'd0, 8'h00, ok);
      wait_resp(lat);
      check("resp_rst_pre_rdata", resp_rdata, 32'hAAAD_CCFE);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("resp_rst_valid", {31'd0, resp_valid}, 32'd0);
      check("resp_rst_rdata", resp_rdata, 32'd0);
      check("resp_rst_req_ready", {31'd0, req_ready}, 32'd1);

`ifdef YSYX_25050147_RAND_DELAY_EN
      begin
         logic [31:0] model [16];
         logic [31:0] exp_rd;
         logic [31:0] data;
         logic [3:0]  mask;
         logic        wen;
         int          idx;
         for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(1'b1, 32'h8000_0000 + 32'(4 * i), model[i], 8'h0F, rd, er);
         end
         for (int i = 0; i < 100; i++) begin
            idx  = $urandom_range(15);
            wen  = 1'($urandom_range(1));
            data = $urandom;
            mask = 4'($urandom_range(15));
            exp_rd = wen ? 32'd0 : model[idx];
            txn(wen, 32'h8000_0000 + 32'(4 * idx), data, {4'h0, mask}, rd, er);
            check("rand_rdata", rd, exp_rd);
            check("rand_err", {31'd0, er}, 32'd0);
            if (wen) begin
               for (int b = 0; b < 4; b++)
                  if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
         end
      end
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
